// File: rtl/layer_sequencer.sv
// Layer sequencer: walks a small descriptor table one layer at a time.
// For each layer it selects the compute engine, pulses a start, waits for
// the engine's done pulse (guarded by a watchdog), optionally flips the
// ping-pong buffer role, then moves to the next layer.
module layer_sequencer #(
   parameter int MAX_LAYERS = 16,
   parameter int IDX_W      = 4,
   parameter int TMO_W      = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_addr,
   input  logic [3:0]       cfg_wdata,
   input  logic [IDX_W:0]   num_layers,
   input  logic             go,
   input  logic             abort,
   input  logic             comp_done,
   output logic [2:0]       comp_sel,
   output logic             comp_start,
   output logic             buf_role,
   output logic [IDX_W-1:0] layer_idx,
   output logic             busy,
   output logic             net_done,
   output logic [1:0]       err
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_START, S_WAIT, S_SWAP, S_FINISH, S_ERROR
   } state_t;

   localparam logic [IDX_W:0] MAX_NL = (IDX_W+1)'(MAX_LAYERS);

   state_t           state, nxt;
   logic [3:0]       tbl [MAX_LAYERS];
   logic [IDX_W:0]   nl_q;
   logic [2:0]       sel_q;
   logic [TMO_W-1:0] wd_q;
   logic [3:0]       ent;
   logic             type_ok;
   logic             is_last;
   logic             wd_max;
   logic             kill;

   assign ent     = tbl[layer_idx];
   assign type_ok = (ent[2:0] == 3'b001) || (ent[2:0] == 3'b010) || (ent[2:0] == 3'b011);
   assign is_last = ({1'b0, layer_idx} == (nl_q - 1'b1));
   assign wd_max  = &wd_q;
   assign kill    = abort && (state != S_IDLE);
   assign busy    = (state != S_IDLE);

   // Descriptor table: writable only while idle, intentionally not reset.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && cfg_we) tbl[cfg_addr] <= cfg_wdata;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= nxt;
   end

   // Next-state and strobes. comp_sel is shown combinationally in FETCH so
   // the engine sees its select one cycle ahead of comp_start.
   always_comb begin
      nxt        = state;
      comp_sel   = 3'b000;
      comp_start = 1'b0;
      net_done   = 1'b0;
      case (state)
         S_IDLE: begin
            if (go) nxt = (num_layers == '0) ? S_FINISH : S_FETCH;
         end
         S_FETCH: begin
            if (type_ok) begin
               comp_sel = ent[2:0];
               nxt      = S_START;
            end else begin
               nxt = S_ERROR;
            end
         end
         S_START: begin
            comp_sel   = sel_q;
            comp_start = 1'b1;
            nxt        = S_WAIT;
         end
         S_WAIT: begin
            comp_sel = sel_q;
            // done beats a simultaneous watchdog expiry
            if (comp_done)   nxt = S_SWAP;
            else if (wd_max) nxt = S_ERROR;
         end
         S_SWAP: begin
            nxt = is_last ? S_FINISH : S_FETCH;
         end
         S_FINISH: begin
            net_done = 1'b1;
            nxt      = S_IDLE;
         end
         S_ERROR: begin
            nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
      // abort overrides everything once a run is in progress
      if (kill) begin
         nxt        = S_ERROR;
         comp_sel   = 3'b000;
         comp_start = 1'b0;
         net_done   = 1'b0;
      end
   end

   // Datapath: layer count, index, select latch, watchdog, buffer role, error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nl_q      <= '0;
         layer_idx <= '0;
         sel_q     <= 3'b000;
         wd_q      <= '0;
         buf_role  <= 1'b0;
         err       <= 2'b00;
      end else if (kill) begin
         err <= 2'b11;
      end else begin
         case (state)
            S_IDLE: begin
               if (go) begin
                  err <= 2'b00;
                  if (num_layers != '0) begin
                     nl_q      <= (num_layers > MAX_NL) ? MAX_NL : num_layers;
                     layer_idx <= '0;
                  end
               end
            end
            S_FETCH: begin
               sel_q <= ent[2:0];
               if (!type_ok) err <= 2'b01;
            end
            S_START: wd_q <= '0;
            S_WAIT: begin
               wd_q <= wd_q + 1'b1;
               if (!comp_done && wd_max) err <= 2'b10;
            end
            S_SWAP: begin
               if (ent[3]) buf_role <= ~buf_role;
               if (!is_last) layer_idx <= layer_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: randomized descriptor tables and done delays,
// checked against a layer-list model kept in the bench.
module tb_layer_sequencer;
   localparam int ML = 16;
   localparam int IW = 4;
   localparam int TW = 4;

   logic          clk = 1'b0, rst = 1'b0;
   logic          cfg_we = 1'b0;
   logic [IW-1:0] cfg_addr = '0;
   logic [3:0]    cfg_wdata = '0;
   logic [IW:0]   num_layers = '0;
   logic          go = 1'b0, abort = 1'b0, comp_done = 1'b0;
   logic [2:0]    comp_sel;
   logic          comp_start, buf_role, busy, net_done;
   logic [IW-1:0] layer_idx;
   logic [1:0]    err;

   layer_sequencer #(.MAX_LAYERS(ML), .IDX_W(IW), .TMO_W(TW)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .num_layers(num_layers), .go(go), .abort(abort), .comp_done(comp_done),
      .comp_sel(comp_sel), .comp_start(comp_start), .buf_role(buf_role),
      .layer_idx(layer_idx), .busy(busy), .net_done(net_done), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_errs = 0;

   // bench image of the descriptor table and the buffer role it expects
   logic [3:0] mtbl [ML];
   logic       mrole = 1'b0;

   // model expectations
   logic [2:0] e_sel[$];
   logic       e_role[$];
   logic [1:0] e_err;
   logic       e_role_end;
   int         e_ndone;

   // observations from one run
   logic [2:0] o_sel[$];
   logic       o_role[$];
   int         o_ndone, o_done_cyc, o_go2first, o_d2s_bad, o_gap_bad, o_pre_bad;
   int         o_err_cyc, o_start_cyc;
   logic [2:0] o_sel_at_err;
   logic [1:0] o_err;
   logic       o_role_end;
   bit         o_tmo;

   // Reference: a network is the list of layers 0..n-1; each valid layer
   // produces one start with its type and the current role, then flips the
   // role if its swap bit is set. An invalid type ends the run with err 01.
   task automatic model(input int n);
      logic r;
      e_sel.delete(); e_role.delete();
      r = mrole; e_err = 2'b00; e_ndone = 1;
      for (int i = 0; i < n; i++) begin
         if (mtbl[i][2:0] < 3'd1 || mtbl[i][2:0] > 3'd3) begin
            e_err = 2'b01; e_ndone = 0; break;
         end
         e_sel.push_back(mtbl[i][2:0]);
         e_role.push_back(r);
         if (mtbl[i][3]) r = ~r;
      end
      e_role_end = r;
   endtask

   task automatic write_entry(input int a, input logic [3:0] d);
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_addr = a[IW-1:0]; cfg_wdata = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      mtbl[a] = d;
   endtask

   // fill n entries with valid random layers; entry 'bad' (if >=0) gets an illegal type
   task automatic program_random(input int n, input int bad);
      logic [2:0] t;
      for (int i = 0; i < n; i++) begin
         t = 3'($urandom_range(1, 3));
         if (i == bad) t = 3'($urandom_range(4, 7));
         write_entry(i, {1'($urandom_range(0, 1)), t});
      end
   endtask

   // Drive one network run and record what the DUT does. Cycle 0 is the go cycle.
   // The engine answers each comp_start with comp_done dly cycles later.
   task automatic run(input int n, input int dly, input int abort_dly, input int mid_cfg, input int mid_go);
      int c, done_at, abort_at, last_done, zeros, idle_cnt;
      logic [2:0] prev_sel;
      o_sel.delete(); o_role.delete();
      o_ndone = 0; o_done_cyc = -1; o_go2first = -1; o_d2s_bad = 0; o_gap_bad = 0; o_pre_bad = 0;
      o_err_cyc = -1; o_start_cyc = -1; o_sel_at_err = 3'bxxx; o_tmo = 0;
      done_at = -1; abort_at = -1; last_done = -1; zeros = 0; idle_cnt = 0; c = 0;
      @(posedge clk); #1;
      go = 1'b1; num_layers = n[IW:0];
      @(negedge clk);
      prev_sel = comp_sel;
      while (1) begin
         @(posedge clk); #1;
         c++;
         go = (mid_go > 0 && c == mid_go);
         if (go) num_layers = 5'd5;
         cfg_we = (mid_cfg > 0 && c == mid_cfg); cfg_addr = '0; cfg_wdata = 4'b0111;
         comp_done = (c == done_at);
         abort = (c == abort_at);
         if (comp_done) begin last_done = c; zeros = 0; end
         @(negedge clk);
         if (!comp_start && comp_sel === 3'b000) zeros++;
         if (comp_start) begin
            o_sel.push_back(comp_sel); o_role.push_back(buf_role);
            if (o_go2first < 0) o_go2first = c;
            if (last_done >= 0 && c - last_done != 3) o_d2s_bad++;
            if (last_done >= 0 && zeros != 1) o_gap_bad++;
            if (prev_sel !== comp_sel) o_pre_bad++;
            o_start_cyc = c; done_at = c + dly;
            if (abort_dly > 0 && abort_at < 0) abort_at = c + abort_dly;
         end
         if (net_done) begin o_ndone++; o_done_cyc = c; end
         if (err !== 2'b00 && o_err_cyc < 0) begin o_err_cyc = c; o_sel_at_err = comp_sel; end
         prev_sel = comp_sel;
         if (!busy) idle_cnt++;
         if (idle_cnt >= 3) break;
         if (c > 2000) begin o_tmo = 1; break; end
      end
      go = 1'b0; comp_done = 1'b0; abort = 1'b0; cfg_we = 1'b0;
      o_err = err; o_role_end = buf_role;
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if ({comp_sel, comp_start, buf_role, layer_idx, busy, net_done, err} !== '0) begin
         n_errs++; $display("FAIL reset_outputs: got %0h expected 0", {comp_sel, comp_start, buf_role, layer_idx, busy, net_done, err});
      end
      @(negedge clk); rst = 1'b1;
      mrole = 1'b0;
   endtask

   task automatic test_basic();
      write_entry(0, 4'b1001); write_entry(1, 4'b0011); write_entry(2, 4'b1010);
      model(3);
      run(3, 10, -1, 0, 0);
      n_checks++; if (o_tmo) begin n_errs++; $display("FAIL basic_budget: run did not return to idle"); end
      n_checks++; if (o_sel.size() != e_sel.size()) begin n_errs++; $display("FAIL basic_nstarts: got %0d expected %0d", o_sel.size(), e_sel.size()); end
      for (int i = 0; i < e_sel.size(); i++) begin
         n_checks++;
         if (i >= o_sel.size() || o_sel[i] !== e_sel[i] || o_role[i] !== e_role[i]) begin
            n_errs++; $display("FAIL basic_layer%0d: got sel %0b role %0b expected sel %0b role %0b",
                               i, (i < o_sel.size()) ? o_sel[i] : 3'bxxx, (i < o_role.size()) ? o_role[i] : 1'bx, e_sel[i], e_role[i]);
         end
      end
      n_checks++; if (o_role_end !== e_role_end) begin n_errs++; $display("FAIL basic_role_end: got %0b expected %0b", o_role_end, e_role_end); end
      n_checks++; if (o_ndone != 1) begin n_errs++; $display("FAIL basic_net_done: got %0d pulses expected 1", o_ndone); end
      n_checks++; if (o_err !== 2'b00) begin n_errs++; $display("FAIL basic_err: got %0b expected 00", o_err); end
      n_checks++; if (o_go2first != 2) begin n_errs++; $display("FAIL basic_go_latency: got %0d expected 2", o_go2first); end
      n_checks++; if (o_d2s_bad != 0 || o_gap_bad != 0 || o_pre_bad != 0) begin
         n_errs++; $display("FAIL basic_spacing: done2start %0d gap %0d presel %0d expected 0 0 0", o_d2s_bad, o_gap_bad, o_pre_bad);
      end
      n_checks++; if (layer_idx !== 4'd2) begin n_errs++; $display("FAIL basic_layer_idx: got %0d expected 2", layer_idx); end
      mrole = e_role_end;
   endtask

   task automatic test_zero_layers();
      run(0, 5, -1, 0, 0);
      n_checks++; if (o_ndone != 1 || o_done_cyc != 1) begin n_errs++; $display("FAIL zero_net_done: got %0d pulses at cycle %0d expected 1 at 1", o_ndone, o_done_cyc); end
      n_checks++; if (o_sel.size() != 0) begin n_errs++; $display("FAIL zero_no_start: got %0d starts expected 0", o_sel.size()); end
      n_checks++; if (o_err !== 2'b00) begin n_errs++; $display("FAIL zero_err: got %0b expected 00", o_err); end
   endtask

   task automatic test_bad_type();
      write_entry(0, {1'b1, 3'($urandom_range(1, 3))}); write_entry(1, 4'b0111);
      model(2);
      run(2, 6, -1, 0, 0);
      n_checks++; if (o_sel.size() != 1 || o_sel[0] !== e_sel[0]) begin n_errs++; $display("FAIL bad_starts: got %0d starts expected 1 of type %0b", o_sel.size(), e_sel[0]); end
      n_checks++; if (o_err !== e_err) begin n_errs++; $display("FAIL bad_err: got %0b expected %0b", o_err, e_err); end
      n_checks++; if (o_ndone != 0 || comp_sel !== 3'b000 || busy !== 1'b0) begin
         n_errs++; $display("FAIL bad_end: done %0d sel %0b busy %0b expected 0 000 0", o_ndone, comp_sel, busy);
      end
      n_checks++; if (o_role_end !== e_role_end) begin n_errs++; $display("FAIL bad_role: got %0b expected %0b", o_role_end, e_role_end); end
      mrole = e_role_end;
   endtask

   task automatic test_timeout();
      write_entry(0, 4'b0010);
      run(1, 100000, -1, 0, 0);
      // WAIT lasts 2^TW cycles (watchdog 0..all-ones), error visible in the next cycle
      n_checks++; if (o_err !== 2'b10) begin n_errs++; $display("FAIL tmo_err: got %0b expected 10", o_err); end
      n_checks++; if (o_err_cyc - o_start_cyc != (1 << TW) + 1) begin
         n_errs++; $display("FAIL tmo_latency: got %0d expected %0d", o_err_cyc - o_start_cyc, (1 << TW) + 1);
      end
      n_checks++; if (o_sel_at_err !== 3'b000 || o_ndone != 0) begin n_errs++; $display("FAIL tmo_end: sel %0b done %0d expected 000 0", o_sel_at_err, o_ndone); end
      // done in the very cycle the watchdog is all-ones still counts
      model(1);
      run(1, 1 << TW, -1, 0, 0);
      n_checks++; if (o_err !== 2'b00 || o_ndone != 1) begin n_errs++; $display("FAIL tmo_edge_done: err %0b done %0d expected 00 1", o_err, o_ndone); end
      run(1, (1 << TW) + 1, -1, 0, 0);
      n_checks++; if (o_err !== 2'b10) begin n_errs++; $display("FAIL tmo_edge_late: got %0b expected 10", o_err); end
      run(1, 5, -1, 0, 0);
      n_checks++; if (o_err !== 2'b00 || o_ndone != 1 || o_sel.size() != 1 || o_sel[0] !== e_sel[0]) begin
         n_errs++; $display("FAIL tmo_rerun: err %0b done %0d starts %0d expected 00 1 1", o_err, o_ndone, o_sel.size());
      end
   endtask

   task automatic test_abort();
      write_entry(0, 4'b1011);
      run(1, 3, 2, 0, 0);
      n_checks++; if (o_err !== 2'b11) begin n_errs++; $display("FAIL abort_err: got %0b expected 11", o_err); end
      n_checks++; if (o_err_cyc != o_start_cyc + 3 || o_sel_at_err !== 3'b000) begin
         n_errs++; $display("FAIL abort_timing: err at +%0d sel %0b expected +3 000", o_err_cyc - o_start_cyc, o_sel_at_err);
      end
      n_checks++; if (o_ndone != 0 || o_sel.size() != 1 || o_role_end !== mrole) begin
         n_errs++; $display("FAIL abort_late_done: done %0d starts %0d role %0b expected 0 1 %0b", o_ndone, o_sel.size(), o_role_end, mrole);
      end
   endtask

   task automatic test_busy_ignore();
      program_random(3, -1);
      model(3);
      run(3, 8, -1, 4, 6);
      n_checks++; if (o_sel.size() != 3 || o_ndone != 1 || o_err !== 2'b00) begin
         n_errs++; $display("FAIL busy_run: starts %0d done %0d err %0b expected 3 1 00", o_sel.size(), o_ndone, o_err);
      end
      n_checks++; if (o_role_end !== e_role_end) begin n_errs++; $display("FAIL busy_role: got %0b expected %0b", o_role_end, e_role_end); end
      mrole = e_role_end;
      model(1);
      run(1, 4, -1, 0, 0);
      n_checks++; if (o_sel.size() != 1 || o_sel[0] !== e_sel[0] || o_err !== 2'b00) begin
         n_errs++; $display("FAIL busy_table_kept: starts %0d sel %0b err %0b expected 1 %0b 00", o_sel.size(), (o_sel.size() > 0) ? o_sel[0] : 3'bxxx, o_err, e_sel[0]);
      end
      mrole = e_role_end;
   endtask

   task automatic test_async_reset();
      int k;
      write_entry(0, 4'b1001);
      @(posedge clk); #1; go = 1'b1; num_layers = 5'd1;
      @(posedge clk); #1; go = 1'b0;
      k = 0;
      while (!comp_start && k < 20) begin @(negedge clk); k++; end
      n_checks++; if (k >= 20) begin n_errs++; $display("FAIL areset_start: got no comp_start expected one within 20 cycles"); end
      repeat (2) @(negedge clk);
      n_checks++; if (busy !== 1'b1 || comp_sel !== 3'b001) begin n_errs++; $display("FAIL areset_pre: busy %0b sel %0b expected 1 001", busy, comp_sel); end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({comp_sel, comp_start, buf_role, layer_idx, busy, net_done, err} !== '0) begin
         n_errs++; $display("FAIL areset_outputs: got %0h expected 0", {comp_sel, comp_start, buf_role, layer_idx, busy, net_done, err});
      end
      @(negedge clk); rst = 1'b1;
      mrole = 1'b0;
   endtask

   task automatic test_random();
      int n, d, bad;
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(1, ML);
         d = $urandom_range(1, 1 << TW);
         bad = (it % 3 == 2) ? $urandom_range(0, n - 1) : -1;
         program_random(n, bad);
         model(n);
         run(n, d, -1, 0, 0);
         n_checks++;
         if (o_tmo || o_sel.size() != e_sel.size() || o_err !== e_err || o_ndone != e_ndone || o_role_end !== e_role_end) begin
            n_errs++; $display("FAIL rand%0d_summary: starts %0d err %0b done %0d role %0b expected %0d %0b %0d %0b",
                               it, o_sel.size(), o_err, o_ndone, o_role_end, e_sel.size(), e_err, e_ndone, e_role_end);
         end
         for (int i = 0; i < e_sel.size(); i++) begin
            n_checks++;
            if (i >= o_sel.size() || o_sel[i] !== e_sel[i] || o_role[i] !== e_role[i]) begin
               n_errs++; $display("FAIL rand%0d_layer%0d: got sel %0b role %0b expected sel %0b role %0b", it, i,
                                  (i < o_sel.size()) ? o_sel[i] : 3'bxxx, (i < o_role.size()) ? o_role[i] : 1'bx, e_sel[i], e_role[i]);
            end
         end
         n_checks++; if (o_d2s_bad != 0 || o_gap_bad != 0 || o_pre_bad != 0) begin
            n_errs++; $display("FAIL rand%0d_spacing: done2start %0d gap %0d presel %0d expected 0 0 0", it, o_d2s_bad, o_gap_bad, o_pre_bad);
         end
         mrole = e_role_end;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_layers();
      test_bad_type();
      test_timeout();
      test_abort();
      test_busy_ignore();
      test_random();
      test_async_reset();
      test_basic();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end
endmodule
